sensors_scan_ctrl: RTL and testbench
====================================

# sensors_scan_ctrl

Sequential scan controller for the temperature-monitoring datapath. It walks the sensor array one index at a time over a shared 8-bit sensor read bus and issues a req/ack read to each enabled sensor. It accumulates the temperature sum and the active-sensor count, then publishes both with a one-cycle done pulse to the averaging/alarm logic downstream. It replaces the wide all-sensors-at-once combinational sum with one shared read port and one adder.

## Interface
- `width`, 200: number of sensors (max 200).
- `TIMEOUT`, 15: REQ cycles without ack before a sensor is abandoned (1..255).

- `clk_i` — in — 1 — clock; all logic on rising edge.
- `rst_i` — in — 1 — reset; **synchronous, active-high**.
- `start_i` — in — 1 — begin a scan.
  - Sampled only in IDLE.
  - Ignored while busy.
- `sensors_en_i` — in — width — per-sensor enable.
  - Snapshotted on the edge that accepts start.
- `sensor_sel_o` — out — 8 — index of the sensor being read.
- `sensor_rd_o` — out — 1 — read request; held high until ack or timeout.
- `sensor_ack_i` — in — 1 — read acknowledge; `sensor_data_i` is valid in the same cycle.
- `sensor_data_i` — in — 8 — unsigned temperature of the selected sensor.
- `busy_o` — out — 1 — high from start acceptance until done, inclusive.
- `done_o` — out — 1 — one-cycle pulse; results are valid from this cycle on.
- `temp_sum_o` — out — 16 — sum of acked temperatures; held until the next done.
- `nr_active_sensors_o` — out — 8 — number of acked sensors; held until the next done.
- `timeout_err_o` — out — 1 — at least one sensor timed out in the last scan; held until the next done.

## Operation
- FSM states and transitions:
  - IDLE, on `start_i`: capture `en_q <= sensors_en_i`, clear `idx`, `acc_sum`, `acc_cnt`, `err`; go to SCAN.
  - SCAN, examines `en_q[idx]`:
    - If set: go to REQ, with `sensor_sel_o <= idx`, `sensor_rd_o <= 1`, `tmo_cnt <= 0`.
    - If clear and `idx == width-1`: go to DONE.
    - If clear otherwise: `idx <= idx+1`, stay in SCAN.
  - REQ on ack:
    - Update `acc_sum += sensor_data_i` (zero-extended) and `acc_cnt += 1`.
    - Clear `sensor_rd_o`.
    - Advance `idx`, or go to DONE if `idx == width-1`.
  - REQ, no ack, `tmo_cnt == TIMEOUT-1`: set `err`, clear `sensor_rd_o`, then advance or go to DONE. No accumulation.
  - REQ, no ack otherwise: `tmo_cnt += 1`.
  - DONE, lasting one cycle:
    - `done_o = 1`.
    - Load `temp_sum_o`, `nr_active_sensors_o` and `timeout_err_o` from the accumulators.
    - Go to IDLE.
- Arithmetic and widths:
  - The worst case, 200×255 = 51000, fits 16 bits, so there is no saturation logic.
  - The count saturates naturally at 200 within 8 bits.
- Boundary conditions:
  - Ack and timeout in the same cycle: ack wins; the data is accumulated and `err` is not set.
  - `sensor_ack_i` outside REQ is ignored.
  - `sensors_en_i` changes mid-scan have no effect until the next start.
  - `start_i` during DONE is ignored; it must be re-asserted in IDLE.
  - All sensors disabled: completes with sum 0, count 0, err 0.
  - `rst_i` mid-scan: immediate return to IDLE; the read request drops on that edge; outputs clear.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE; `idx`, accumulators and `en_q` are 0.
- All outputs are registered; no combinational input-to-output path.
- Scan duration:
  - Disabled sensor: 1 cycle.
  - Enabled sensor acked in the L-th REQ cycle: 1+L cycles.
  - Timed-out sensor: 1+TIMEOUT cycles.
- `done_o` rises W + ΣL edges after the start-sampling edge. Example: all disabled, width=200 → 200 edges.
- Back-to-back scans: the earliest next start is accepted on the edge after the done cycle (in IDLE).
- `busy_o` is high exactly during SCAN, REQ and DONE.

## Structure
- Shared package `sensors_pkg` holds:
  - `NR_SENSORS=200`, `DATA_W=8`, `SUM_W=16`, `CNT_W=8`, default `TIMEOUT`.
  - FSM state encodings: IDLE, SCAN, REQ, DONE.
- One sub-module, `sensors_accumulator`: sum/count registers with `clear`, `add_en` and `data` ports, instantiated once.
- FSM, index counter and timeout counter stay in the top module.

## Test plan
- Reset check: assert reset mid-scan while in REQ → next cycle `sensor_rd_o=0`, `busy_o=0`, all outputs 0.
- All disabled: width=200, `sensors_en_i=0`, start → `done_o` 200 edges later; sum 0, count 0, err 0.
- Three enabled sensors, immediate ack (L=1):
  - Sensors 0, 5 and 199 with data 25, 30, 255.
  - Expect sum 310, count 3, err 0; done at 200+3 edges.
- All 200 enabled, each returning 255 with ack latency 3 → sum 51000, count 200, err 0.
- Timeout: sensor 7 never acks, TIMEOUT=15 → `sensor_rd_o` high for exactly 15 cycles; sensor 7 excluded from sum/count; `timeout_err_o=1`.
- Races:
  - Ack on the same cycle as timeout → data accumulated, err 0.
  - `start_i` held high through a scan → exactly one scan per IDLE acceptance.
  - `sensors_en_i` toggled mid-scan → result reflects the snapshot.

Source files
------------

// File: rtl/sensors_pkg.sv
// Shared widths, defaults and FSM encoding for the sensor scan controller.
package sensors_pkg;

  localparam int unsigned NR_SENSORS       = 200;
  localparam int unsigned DATA_W           = 8;
  localparam int unsigned SUM_W            = 16;
  localparam int unsigned CNT_W            = 8;
  localparam int unsigned IDX_W            = 8;
  localparam int unsigned TMO_W            = 8;
  localparam int unsigned SCAN_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_REQ  = 2'd2,
    ST_DONE = 2'd3
  } scan_state_e;

endpackage

// File: rtl/sensors_accumulator.sv
// Temperature sum and active-sensor count registers.
// The next-state values are exported so results can be published on the final edge.
module sensors_accumulator
  import sensors_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              add_en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [SUM_W-1:0]  sum_nxt_c_o,
  output logic [CNT_W-1:0]  cnt_nxt_c_o
);

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (add_en_i) begin
      sum_d = sum_q + SUM_W'(data_i);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum_nxt_c_o = sum_d;
  assign cnt_nxt_c_o = cnt_d;

endmodule

// File: rtl/sensors_scan_ctrl.sv
// Sequential sensor scan: one shared req/ack read port, one adder, results
// published with a one-cycle done pulse.
module sensors_scan_ctrl
  import sensors_pkg::*;
#(
  parameter int unsigned width   = NR_SENSORS,
  parameter int unsigned TIMEOUT = SCAN_TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [width-1:0]  sensors_en_i,
  output logic [IDX_W-1:0]  sensor_sel_o,
  output logic              sensor_rd_o,
  input  logic              sensor_ack_i,
  input  logic [DATA_W-1:0] sensor_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [SUM_W-1:0]  temp_sum_o,
  output logic [CNT_W-1:0]  nr_active_sensors_o,
  output logic              timeout_err_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(width - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  scan_state_e      state_q, state_d;
  logic [width-1:0] en_q, en_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             rd_q, rd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SUM_W-1:0] sum_out_q, sum_out_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic             tmo_err_q, tmo_err_d;

  logic             acc_clear, acc_add, advance;
  logic [SUM_W-1:0] acc_sum_nxt;
  logic [CNT_W-1:0] acc_cnt_nxt;

  sensors_accumulator u_acc (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (acc_clear),
    .add_en_i    (acc_add),
    .data_i      (sensor_data_i),
    .sum_nxt_c_o (acc_sum_nxt),
    .cnt_nxt_c_o (acc_cnt_nxt)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    sel_d     = sel_q;
    rd_d      = rd_q;
    sum_out_d = sum_out_q;
    cnt_out_d = cnt_out_q;
    tmo_err_d = tmo_err_q;
    acc_clear = 1'b0;
    acc_add   = 1'b0;
    advance   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          en_d      = sensors_en_i;
          idx_d     = '0;
          err_d     = 1'b0;
          acc_clear = 1'b1;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (en_q[idx_q]) begin
          sel_d   = idx_q;
          rd_d    = 1'b1;
          tmo_d   = '0;
          state_d = ST_REQ;
        end else begin
          advance = 1'b1;
        end
      end
      ST_REQ: begin
        // Ack takes priority over a coincident timeout
        if (sensor_ack_i) begin
          acc_add = 1'b1;
          rd_d    = 1'b0;
          advance = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          rd_d    = 1'b0;
          advance = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = ST_DONE;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = ST_SCAN;
      end
    end

    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
    if (done_d) begin
      sum_out_d = acc_sum_nxt;
      cnt_out_d = acc_cnt_nxt;
      tmo_err_d = err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      en_q      <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      sel_q     <= '0;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_out_q <= '0;
      cnt_out_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      sel_q     <= sel_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sum_out_q <= sum_out_d;
      cnt_out_q <= cnt_out_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign sensor_sel_o        = sel_q;
  assign sensor_rd_o         = rd_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign temp_sum_o          = sum_out_q;
  assign nr_active_sensors_o = cnt_out_q;
  assign timeout_err_o       = tmo_err_q;

endmodule

// File: tb/tb_sensors_scan_ctrl.sv
// Directed bench for sensors_scan_ctrl: a sensor responder model plus
// hand-computed sums, counts and done latencies.
module tb_sensors_scan_ctrl;

  localparam int unsigned W   = 200;
  localparam int unsigned TMO = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   sensors_en;
  logic [7:0]     sensor_sel;
  logic           sensor_rd;
  logic           sensor_ack;
  logic [7:0]     sensor_data;
  logic           busy;
  logic           done;
  logic [15:0]    temp_sum;
  logic [7:0]     nr_active;
  logic           timeout_err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] data_tab [256];
  int lat        = 1;
  int noack_idx  = -1;
  bit stray      = 1'b0;
  int req_cyc    = 0;
  int rd_hi_max  = 0;

  always #5 clk = ~clk;

  sensors_scan_ctrl #(.width(W), .TIMEOUT(TMO)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start),
    .sensors_en_i        (sensors_en),
    .sensor_sel_o        (sensor_sel),
    .sensor_rd_o         (sensor_rd),
    .sensor_ack_i        (sensor_ack),
    .sensor_data_i       (sensor_data),
    .busy_o              (busy),
    .done_o              (done),
    .temp_sum_o          (temp_sum),
    .nr_active_sensors_o (nr_active),
    .timeout_err_o       (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sensor model: acks in the lat-th REQ cycle unless it is the dead sensor
  initial begin
    sensor_ack  = 1'b0;
    sensor_data = 8'h00;
    forever begin
      @(negedge clk);
      if (sensor_rd) begin
        req_cyc++;
        if (req_cyc > rd_hi_max) rd_hi_max = req_cyc;
        if (req_cyc == lat && int'(sensor_sel) != noack_idx) begin
          sensor_ack  = 1'b1;
          sensor_data = data_tab[sensor_sel];
        end else begin
          sensor_ack  = 1'b0;
          sensor_data = 8'h00;
        end
      end else begin
        req_cyc     = 0;
        sensor_ack  = stray;
        sensor_data = stray ? 8'hFF : 8'h00;
      end
    end
  end

  task automatic run_scan(input logic [W-1:0] en, input logic [W-1:0] en_after, output int cycles);
    @(negedge clk);
    sensors_en = en;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    sensors_en = en_after;
    check_eq("busy_at_accept", 32'(busy), 32'd1);
    cycles = -1;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int cycles, input int exp_cyc,
                              input int exp_sum, input int exp_cnt, input int exp_err);
    check_eq({tag, "_latency"}, 32'(cycles), 32'(exp_cyc));
    check_eq({tag, "_sum"}, 32'(temp_sum), 32'(exp_sum));
    check_eq({tag, "_cnt"}, 32'(nr_active), 32'(exp_cnt));
    check_eq({tag, "_err"}, 32'(timeout_err), 32'(exp_err));
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] en;
    int cyc;
    int n_done;

    for (int i = 0; i < 256; i++) data_tab[i] = 8'h00;
    rst        = 1'b1;
    start      = 1'b0;
    sensors_en = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd", 32'(sensor_rd), 32'd0);
    check_eq("rst_sum", 32'(temp_sum), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All disabled: 200 edges, empty result
    run_scan('0, '0, cyc);
    check_result("all_off", cyc, 200, 0, 0, 0);

    // Sensors 0, 5, 199 with L=1; stray acks outside REQ must be ignored
    en = '0;
    en[0] = 1'b1; en[5] = 1'b1; en[199] = 1'b1;
    data_tab[0] = 8'd25; data_tab[5] = 8'd30; data_tab[199] = 8'd255;
    lat   = 1;
    stray = 1'b1;
    run_scan(en, en, cyc);
    check_result("three", cyc, 203, 310, 3, 0);
    stray = 1'b0;

    // All enabled, 255 each, ack latency 3
    for (int i = 0; i < 256; i++) data_tab[i] = 8'd255;
    lat = 3;
    run_scan('1, '1, cyc);
    check_result("all_on", cyc, 800, 51000, 200, 0);

    // Sensor 7 never acks, sensor 9 acks 40
    data_tab[9] = 8'd40;
    lat       = 1;
    noack_idx = 7;
    rd_hi_max = 0;
    en = '0;
    en[7] = 1'b1; en[9] = 1'b1;
    run_scan(en, en, cyc);
    check_eq("tmo_rd_cycles", 32'(rd_hi_max), 32'(TMO));
    check_result("timeout", cyc, 216, 40, 1, 1);

    // Ack on the same cycle as the timeout: ack wins
    noack_idx   = -1;
    lat         = TMO;
    data_tab[4] = 8'd77;
    en = '0;
    en[4] = 1'b1;
    run_scan(en, en, cyc);
    check_result("ack_tmo_race", cyc, 215, 77, 1, 0);

    // Enables changed after start: snapshot governs
    lat          = 1;
    data_tab[3]  = 8'd10;
    data_tab[10] = 8'd20;
    en = '0;
    en[3] = 1'b1; en[10] = 1'b1;
    run_scan(en, '1, cyc);
    check_result("en_snapshot", cyc, 202, 30, 2, 0);

    // Start held high: one scan per IDLE acceptance (period 202 edges)
    @(negedge clk);
    sensors_en = '0;
    start      = 1'b1;
    n_done     = 0;
    for (int k = 0; k < 450; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check_eq("start_held_dones", 32'(n_done), 32'd2);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check_eq("start_held_drain", 32'(busy), 32'd0);

    // Reset while a request is outstanding
    noack_idx = 7;
    en = '0;
    en[7] = 1'b1;
    run_scan(en, en, cyc);
    check_result("pre_reset", cyc, 215, 0, 0, 1);
    @(negedge clk);
    sensors_en = en;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (sensor_rd) break;
    end
    check_eq("mid_rd_high", 32'(sensor_rd), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_rd", 32'(sensor_rd), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_err", 32'(timeout_err), 32'd0);
    check_eq("mid_rst_sel", 32'(sensor_sel), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    noack_idx = -1;

    // Clean scan after reset
    run_scan('0, '0, cyc);
    check_result("post_reset", cyc, 200, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
